// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing generator for the HDMI transmit path. A horizontal counter
// and a vertical counter walk the raster. Every output is a registered
// decode of the counter value consumed on the same clock edge.
//
// Each line runs active, front porch, sync, back porch. Each frame runs in
// the same order, counted in lines.
//
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous active-high reset
//   en          in   synchronous enable; 0 freezes the counters and all outputs
//   de          out  data enable, high in the visible region
//   hsync       out  horizontal sync, active level HS_POL
//   vsync       out  vertical sync, active level VS_POL
//   x [11:0]    out  horizontal position, 0..H_TOTAL-1
//   y [10:0]    out  vertical position, 0..V_TOTAL-1
//   line_start  out  high while x==0
//   frame_start out  high while x==0 and y==0
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] H_SSTRT = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SEND  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] V_SSTRT = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SEND  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] r_h_cnt;
  logic [10:0] r_v_cnt;

  logic [11:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_de;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_line_start;
  logic        w_frame_start;

  // Next counter values and the decode of the position being consumed now.
  always_comb begin
    w_h_last = (r_h_cnt == H_LAST);
    w_v_last = (r_v_cnt == V_LAST);
    w_h_next = r_h_cnt + 12'd1;
    w_v_next = r_v_cnt;
    if (w_h_last) begin
      w_h_next = 12'd0;
      // The vertical counter moves only when the line wraps. At the last
      // line it wraps together with the horizontal counter.
      if (w_v_last) begin
        w_v_next = 11'd0;
      end else begin
        w_v_next = r_v_cnt + 11'd1;
      end
    end else begin
      w_h_next = r_h_cnt + 12'd1;
      w_v_next = r_v_cnt;
    end

    w_de = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    if ((r_h_cnt >= H_SSTRT) && (r_h_cnt < H_SEND)) begin
      w_hsync = HS_POL;
    end else begin
      w_hsync = ~HS_POL;
    end
    // This decode depends only on the line number, so vsync can change only
    // where the line changes, which is the x==0 position.
    if ((r_v_cnt >= V_SSTRT) && (r_v_cnt < V_SEND)) begin
      w_vsync = VS_POL;
    end else begin
      w_vsync = ~VS_POL;
    end
    w_line_start  = (r_h_cnt == 12'd0);
    w_frame_start = (r_h_cnt == 12'd0) && (r_v_cnt == 11'd0);
  end

  // Counters and registered outputs. When en is low, every register holds,
  // including the one-cycle markers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt     <= 12'd0;
      r_v_cnt     <= 11'd0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      x           <= 12'd0;
      y           <= 11'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      r_h_cnt     <= w_h_next;
      r_v_cnt     <= w_v_next;
      de          <= w_de;
      hsync       <= w_hsync;
      vsync       <= w_vsync;
      x           <= r_h_cnt;
      y           <= r_v_cnt;
      line_start  <= w_line_start;
      frame_start <= w_frame_start;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. Instance A uses the default 640x480
// timing. Instance B uses the 8x5 reduced raster.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst_a, en_a, de_a, hs_a, vs_a, ls_a, fs_a;
  logic [11:0] x_a;
  logic [10:0] y_a;
  logic        rst_b, en_b, de_b, hs_b, vs_b, ls_b, fs_b;
  logic [11:0] x_b;
  logic [10:0] y_b;

  video_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  // Output bundle order: {de, hsync, vsync, x, y, line_start, frame_start}
  wire [27:0] obs_a = {de_a, hs_a, vs_a, x_a, y_a, ls_a, fs_a};
  wire [27:0] obs_b = {de_b, hs_b, vs_b, x_b, y_b, ls_b, fs_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    #2;
    n_tests++;
    if (obs_a !== {1'b0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_a: got %h want %h", obs_a, {1'b0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0});
    end
    tick();
    n_tests++;
    if (obs_b !== {1'b0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_b_held: got %h want %h", obs_b, {1'b0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0});
    end
    rst_a = 1'b0;
    tick();
    n_tests++;
    if (obs_a !== {1'b1, 1'b1, 1'b1, 12'd0, 11'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL first_edge_a: got %h want %h", obs_a, {1'b1, 1'b1, 1'b1, 12'd0, 11'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_line0();
    int bad = 0;
    int hs_low = 0;
    int de_cnt = 0;
    for (int i = 1; i < 800; i++) begin
      tick();
      if (de_a) de_cnt++;
      if (!hs_a) hs_low++;
      if ((bad == 0) && ((x_a !== 12'(i)) || (y_a !== 11'd0) || (de_a !== (i < 640)) ||
          (hs_a !== !((i >= 656) && (i < 752))) || (vs_a !== 1'b1) || (ls_a !== 1'b0) || (fs_a !== 1'b0))) begin
        bad = 1;
        $display("FAIL line0_x%0d: got x=%0d y=%0d de=%b hs=%b ls=%b fs=%b", i, x_a, y_a, de_a, hs_a, ls_a, fs_a);
      end
    end
    n_tests++; if (bad != 0) n_fail++;
    n_tests++;
    if (hs_low != 96) begin n_fail++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
    n_tests++;
    if (de_cnt != 639) begin n_fail++; $display("FAIL de_count_line0: got %0d want 639", de_cnt); end
    tick();
    n_tests++;
    if (obs_a !== {1'b1, 1'b1, 1'b1, 12'd0, 11'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL line1_start: got %h want %h", obs_a, {1'b1, 1'b1, 1'b1, 12'd0, 11'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_freeze();
    int bad = 0;
    // The outputs show (0,1). 1700 more edges bring them to (100,3).
    for (int i = 0; i < 1700; i++) tick();
    n_tests++;
    if ((x_a !== 12'd100) || (y_a !== 11'd3)) begin
      n_fail++; $display("FAIL freeze_pos: got x=%0d y=%0d want 100,3", x_a, y_a);
    end
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (obs_a !== {1'b1, 1'b1, 1'b1, 12'd100, 11'd3, 1'b0, 1'b0}) bad = 1;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL freeze_hold: got %h want %h", obs_a, {1'b1, 1'b1, 1'b1, 12'd100, 11'd3, 1'b0, 1'b0});
    end
    en_a = 1'b1;
    tick();
    n_tests++;
    if ((x_a !== 12'd101) || (y_a !== 11'd3)) begin
      n_fail++; $display("FAIL freeze_resume: got x=%0d y=%0d want 101,3", x_a, y_a);
    end
  endtask

  task automatic test_async_reset();
    // From (101,3), 999 more edges bring the outputs to (300,4).
    for (int i = 0; i < 999; i++) tick();
    n_tests++;
    if ((x_a !== 12'd300) || (y_a !== 11'd4) || (de_a !== 1'b1)) begin
      n_fail++; $display("FAIL pre_reset_pos: got x=%0d y=%0d de=%b want 300,4,1", x_a, y_a, de_a);
    end
    #2 rst_a = 1'b1;
    #1;
    n_tests++;
    if (obs_a !== {1'b0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs_a, {1'b0, 1'b1, 1'b1, 12'd0, 11'd0, 1'b0, 1'b0});
    end
    tick();
    rst_a = 1'b0;
    tick();
    n_tests++;
    if (obs_a !== {1'b1, 1'b1, 1'b1, 12'd0, 11'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_restart: got %h want %h", obs_a, {1'b1, 1'b1, 1'b1, 12'd0, 11'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_small_pattern();
    int bad = 0;
    int fs_cnt = 0;
    int ls_cnt = 0;
    int de_cnt = 0;
    int vs_low = 0;
    logic [11:0] ex;
    logic [10:0] ey;
    rst_b = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      ex = 12'(k % 8);
      ey = 11'((k / 8) % 5);
      if (fs_b) fs_cnt++;
      if (ls_b) ls_cnt++;
      if (de_b) de_cnt++;
      if (!vs_b) vs_low++;
      if ((bad == 0) && (obs_b !== {(ex < 12'd4) && (ey < 11'd2), !((ex == 12'd5) || (ex == 12'd6)),
          (ey != 11'd3), ex, ey, (ex == 12'd0), (k % 40 == 0)})) begin
        bad = 1;
        $display("FAIL small_cycle%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d",
                 k, x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b, ex, ey);
      end
    end
    n_tests++; if (bad != 0) n_fail++;
    n_tests++;
    if (fs_cnt != 2) begin n_fail++; $display("FAIL small_frame_count: got %0d want 2", fs_cnt); end
    n_tests++;
    if (ls_cnt != 10) begin n_fail++; $display("FAIL small_line_count: got %0d want 10", ls_cnt); end
    n_tests++;
    if (de_cnt != 16) begin n_fail++; $display("FAIL small_de_count: got %0d want 16", de_cnt); end
    n_tests++;
    if (vs_low != 16) begin n_fail++; $display("FAIL small_vsync_width: got %0d want 16", vs_low); end
  endtask

  task automatic test_small_pulse_hold();
    int bad = 0;
    // After 80 edges the position (0,0) is the next one to be presented.
    tick();
    n_tests++;
    if ((fs_b !== 1'b1) || (x_b !== 12'd0) || (y_b !== 11'd0)) begin
      n_fail++; $display("FAIL small_wrap: got x=%0d y=%0d fs=%b want 0,0,1", x_b, y_b, fs_b);
    end
    en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((fs_b !== 1'b1) || (ls_b !== 1'b1) || (x_b !== 12'd0)) bad = 1;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL pulse_hold: got fs=%b ls=%b x=%0d want 1,1,0", fs_b, ls_b, x_b); end
    en_b = 1'b1;
    tick();
    n_tests++;
    if ((x_b !== 12'd1) || (fs_b !== 1'b0) || (ls_b !== 1'b0)) begin
      n_fail++; $display("FAIL pulse_resume: got x=%0d fs=%b ls=%b want 1,0,0", x_b, fs_b, ls_b);
    end
  endtask

  initial begin
    test_reset();
    test_line0();
    test_freeze();
    test_async_reset();
    test_small_pattern();
    test_small_pulse_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI transmit path: DE, HSYNC, VSYNC, pixel coordinates and frame/line markers.
- Sits directly upstream of the three per-channel TMDS encoders:
  - de drives each encoder's data_en.
  - hsync/vsync drive the blue channel's ctrl0_in/ctrl1_in.
  - x/y address the pixel source.
- Fully registered outputs; free-running once enabled.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  input  1  pixel clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  synchronous enable; 0 freezes counters and all outputs
- de  output  1  data enable, high in the visible region
- hsync  output  1  horizontal sync at polarity HS_POL
- vsync  output  1  vertical sync at polarity VS_POL
- x  output  12  horizontal position, 0..H_TOTAL-1
- y  output  11  vertical position, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse at x==0
- frame_start  output  1  one-cycle pulse at x==0, y==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Totals must fit the 12/11-bit ports.
- Line order: active, front porch, sync, back porch. Frame order is the same, in lines.
- Internal counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the h_cnt wrap; it runs 0..V_TOTAL-1 and wraps to 0 on the same edge that h_cnt wraps at v_cnt==V_TOTAL-1.
- Outputs are registered decodes of the current counter value. The edge that consumes counter (h,v) presents position (h,v) on the outputs and advances the counter. Latency from counter to outputs is 1 cycle.
- Decodes for position (h,v):
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. vsync changes only on line boundaries (x==0).
  - x = h, y = v
  - line_start = (h==0)
  - frame_start = (h==0 && v==0)
- Reset values (asynchronous): h_cnt=0, v_cnt=0, de=0, hsync=~HS_POL, vsync=~VS_POL, x=0, y=0, line_start=0, frame_start=0.
- After rst deasserts with en=1, the first rising edge presents (0,0): de=1, line_start=1, frame_start=1.
- en=0: counters and every output hold their current value. Pulses are also held, so the downstream must qualify pulses with en. Resumption continues from the held position with no skipped or duplicated position.
- rst asserted mid-frame: immediate return to the reset values above; the frame restarts at (0,0).
- Downstream is responsible for matching pixel-data latency to de. The TMDS encoder pipelines de, ctrl and data identically, so no compensation is needed inside this block.

Test Plan:
- Default params, en=1 for one full frame -> exactly 420000 cycles between frame_start pulses; 307200 cycles with de=1; 525 line_start pulses.
- Default params, inspect line 0 -> de high for x 0..639; hsync low exactly for x 656..751 (96 cycles); hsync high elsewhere.
- Default params, inspect frame -> vsync low exactly for y 490..491, transitioning on the x==0 cycle; de never high for y>=480.
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1:
  - x sequence 0..7 repeating.
  - y wraps 4 -> 0 on the same edge x wraps 7 -> 0.
  - Pattern repeats every 40 cycles.
- en=0 held for 5 cycles at x=100, y=3 -> all outputs frozen; first cycle after en=1 presents x=101, y=3.
- rst asserted asynchronously at x=300, y=200 -> outputs immediately show the reset values; first edge after release presents (0,0) with frame_start=1.
